mem_sp_clr: RTL and testbench
=============================

// Module: mem_sp_clr
// PURPOSE
//  Parametrised single-port RAM, next generation of the 10x32 scratch memory.
//  Registered (synchronous) read with valid strobe. Built-in clear engine writes
//  INIT_VAL to every entry after reset or on request, so content is defined after POR.
//  Used as a generic register-file or lookup store for datapath blocks in one clock domain.
// PARAMETERS
//  DW        10         data width in bits (>=1)
//  DEPTH     32         number of entries (>=2, power of 2 not required)
//  INIT_VAL  '0         value written to every entry by the clear engine (DW bits)
//  AW        $clog2(DEPTH)  address width, derived, not to be overridden
// PORTS
//  clk       in   1    clock, all logic on rising edge
//  rst_n     in   1    asynchronous active-low reset
//  clr       in   1    request full clear (sampled only in READY)
//  busy      out  1    1 = clear in progress, all access requests dropped
//  addr      in   AW   access address
//  we        in   1    write enable
//  re        in   1    read enable
//  data_in   in   DW   write data
//  data_out  out  DW   registered read data, holds until next accepted read
//  rd_valid  out  1    1-cycle pulse, data_out updated this cycle
//  par_inj   in   1    (MEM_PARITY_EN only) invert stored parity on this write
//  par_err   out  1    (MEM_PARITY_EN only) parity mismatch, aligned with rd_valid
// BEHAVIOUR
//  Reset values: busy=1, data_out=0, rd_valid=0, par_err=0, state=CLEAR, clr_ptr=0.
//  Array itself has no reset; it is initialised only by the clear engine.
//  FSM: CLEAR -> READY when clr_ptr==DEPTH-1 (that entry written in same cycle).
//       READY -> CLEAR when clr=1; clr_ptr restarts at 0 next cycle.
//  CLEAR: one entry per cycle, mem[clr_ptr]<=INIT_VAL, clr_ptr++; takes exactly DEPTH
//    cycles; busy deasserts on cycle after last entry write.
//  busy=1: we/re/clr ignored (not queued); rd_valid stays 0; data_out holds.
//  Write: READY & we -> mem[addr]<=data_in at edge.
//  Read: READY & re -> data_out<=mem[addr] at edge, rd_valid=1 that next cycle. Latency 1.
//  Back-to-back reads allowed every cycle; rd_valid stays high for consecutive reads.
//  we & re same addr same cycle: read-first, data_out gets old content.
//  clr & we/re same cycle in READY: clr wins, access dropped, no rd_valid.
//  addr >= DEPTH (non-power-of-2 DEPTH): write dropped; read returns 0, rd_valid=1.
//  rst_n asserted mid-clear or mid-read: outputs to reset values immediately,
//    clear restarts from entry 0 after release; partially cleared content is don't-care.
// CONFIGURATION
//  `define MEM_PARITY_EN: array stores DW+1 bits, extra bit = even parity (^data_in),
//    XOR par_inj on write. On read, par_err<=parity mismatch, with rd_valid timing;
//    0 when no read. Clear engine writes correct parity for INIT_VAL.
//  Without MEM_PARITY_EN: array is DW bits, par_inj/par_err ports absent.
// TESTING (defaults DW=10, DEPTH=32, INIT_VAL=0 unless noted)
//  1 Release rst_n -> busy=1 for exactly 32 cycles, then 0; read addr 0..31 -> 0x000.
//  2 INIT_VAL=10'h155, DEPTH=20: after clear, read addr 19 -> 0x155; write addr 25
//    then read addr 25 -> data_out=0, rd_valid=1.
//  3 Write 0x2A5 @3, next cycle re @3 -> following cycle data_out=0x2A5, rd_valid=1 one cycle.
//  4 Mem[7]=0x011; we=1,re=1 @7 data_in=0x3FF -> data_out=0x011; re @7 again -> 0x3FF.
//  5 clr=1 with we @5 -> write dropped, busy 32 cycles, mem[5]=INIT_VAL; re during busy -> no rd_valid.
//  6 MEM_PARITY_EN: write 0x001 @2 par_inj=1, read @2 -> par_err=1; read @4 -> par_err=0.
//    Assert rst_n mid-clear at cycle 10 -> busy stays 1, full 32-cycle clear after release.

Source files
------------

// File: rtl/mem_sp_clr.sv
// -----------------------------------------------------------------------------
// mem_sp_clr
//   Single-port RAM with registered read, read-valid strobe and a built-in
//   clear engine. After reset, or on request, the engine writes INIT_VAL to
//   every entry at one entry per cycle. While it runs, busy_o is high and all
//   access requests are dropped.
//
//   Optional build macro: MEM_PARITY_EN
//     Each entry stores one extra even-parity bit. par_inj_i inverts the stored
//     parity on a write. par_err_o flags a parity mismatch and is aligned with
//     rd_valid_o.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr_i        request a full clear (only sampled when not busy)
//   busy_o       clear in progress
//   addr_i       access address
//   we_i         write enable
//   re_i         read enable
//   data_in_i    write data
//   data_out_o   registered read data, holds until the next accepted read
//   rd_valid_o   one-cycle strobe: data_out_o was updated this cycle
//   par_inj_i    (MEM_PARITY_EN) invert the stored parity on this write
//   par_err_o    (MEM_PARITY_EN) parity mismatch on the returned read
//
// States
//   state    | meaning
//   ST_CLEAR | engine writes INIT_VAL to mem[clr_ptr_q]; accesses are dropped
//   ST_READY | normal read/write access; clr_i restarts the clear
// -----------------------------------------------------------------------------
module mem_sp_clr #(
    parameter int              DW       = 10,
    parameter int              DEPTH    = 32,
    parameter logic [DW-1:0]   INIT_VAL = '0,
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    output logic          busy_o,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [DW-1:0] data_in_i,
    output logic [DW-1:0] data_out_o,
    output logic          rd_valid_o
`ifdef MEM_PARITY_EN
    ,
    input  logic          par_inj_i,
    output logic          par_err_o
`endif
);

`ifdef MEM_PARITY_EN
    localparam int MW = DW + 1;
    // Parity bit sits above the data bits.
    localparam logic [MW-1:0] INIT_WORD = {^INIT_VAL, INIT_VAL};
`else
    localparam int MW = DW;
    localparam logic [MW-1:0] INIT_WORD = INIT_VAL;
`endif

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            rd_valid_q, rd_valid_d;
`ifdef MEM_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    logic [MW-1:0]   mem [DEPTH];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [MW-1:0]   mem_wdata;
    logic [MW-1:0]   wr_word;
    logic [MW-1:0]   rd_word;
    logic            addr_ok;

    // Only matters when DEPTH is not a power of two.
    assign addr_ok = (int'(addr_i) < DEPTH);

    // Out-of-range reads return all zeros, which also has consistent parity.
    assign rd_word = addr_ok ? mem[addr_i] : '0;

`ifdef MEM_PARITY_EN
    assign wr_word = {(^data_in_i) ^ par_inj_i, data_in_i};
`else
    assign wr_word = data_in_i;
`endif

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_i;
        mem_wdata  = wr_word;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
`ifdef MEM_PARITY_EN
        par_err_d  = 1'b0;
`endif
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = INIT_WORD;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    // Clear wins over any access presented in the same cycle.
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    if (we_i && addr_ok) begin
                        mem_we = 1'b1;
                    end
                    if (re_i) begin
                        // Array write lands at the same edge, so this is read-first.
                        data_out_d = rd_word[DW-1:0];
                        rd_valid_d = 1'b1;
`ifdef MEM_PARITY_EN
                        par_err_d  = rd_word[DW] ^ (^rd_word[DW-1:0]);
`endif
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
`ifdef MEM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
`ifdef MEM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Array has no reset; the clear engine defines its content.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign data_out_o = data_out_q;
    assign rd_valid_o = rd_valid_q;
`ifdef MEM_PARITY_EN
    assign par_err_o  = par_err_q;
`endif

endmodule

// File: tb/tb_mem_sp_clr.sv
module tb_mem_sp_clr;

    localparam int DW   = 10;
    localparam int AW   = 5;
    localparam int D32  = 32;
    localparam int D20  = 20;
    localparam int INIT20 = 'h155;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          clr_a, we_a, re_a, busy_a, vld_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a, dout_a;

    logic          clr_b, we_b, re_b, busy_b, vld_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b, dout_b;

`ifdef MEM_PARITY_EN
    logic          inj_a, perr_a, inj_b, perr_b;
`endif

    int checks   = 0;
    int failures = 0;

    int mdl [D32];
    int mdl20 [D20];
    int exp_data;
    int cnt_a, cnt_b;

    always #5 clk = ~clk;

    mem_sp_clr #(.DW(DW), .DEPTH(D32), .INIT_VAL('0)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_a),
        .busy_o     (busy_a),
        .addr_i     (addr_a),
        .we_i       (we_a),
        .re_i       (re_a),
        .data_in_i  (din_a),
        .data_out_o (dout_a),
        .rd_valid_o (vld_a)
`ifdef MEM_PARITY_EN
        ,
        .par_inj_i  (inj_a),
        .par_err_o  (perr_a)
`endif
    );

    mem_sp_clr #(.DW(DW), .DEPTH(D20), .INIT_VAL(10'h155)) u_dut20 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_b),
        .busy_o     (busy_b),
        .addr_i     (addr_b),
        .we_i       (we_b),
        .re_i       (re_b),
        .data_in_i  (din_b),
        .data_out_o (dout_b),
        .rd_valid_o (vld_b)
`ifdef MEM_PARITY_EN
        ,
        .par_inj_i  (inj_b),
        .par_err_o  (perr_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        clr_a = 0; we_a = 0; re_a = 0; addr_a = '0; din_a = '0;
    endtask

    // Counts samples with busy high (sample right after release included).
    task automatic count_busy(output int na, output int nb);
        na = 0; nb = 0;
        for (int c = 0; c < 200; c++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (!busy_a && !busy_b) break;
            step();
        end
    endtask

    task automatic write_a(input int a, input int d);
        we_a = 1; re_a = 0; addr_a = AW'(a); din_a = DW'(d);
        step();
        mdl[a] = d;
        we_a = 0;
    endtask

    task automatic read_a(input string tag, input int a);
        re_a = 1; we_a = 0; addr_a = AW'(a);
        step();
        re_a = 0;
        check({tag, "_vld"}, 32'(vld_a), 32'd1);
        check({tag, "_data"}, 32'(dout_a), 32'(mdl[a]));
    endtask

    initial begin
        rst_n = 0;
        idle_a();
        clr_b = 0; we_b = 0; re_b = 0; addr_b = '0; din_b = '0;
`ifdef MEM_PARITY_EN
        inj_a = 0; inj_b = 0;
`endif
        for (int i = 0; i < D32; i++) mdl[i] = 0;
        for (int i = 0; i < D20; i++) mdl20[i] = INIT20;

        // Reset values
        step(); step();
        re_a = 1;
        step();
        check("rst_busy", 32'(busy_a), 32'd1);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_vld", 32'(vld_a), 32'd0);
        re_a = 0;

        // Initial clear length
        rst_n = 1;
        count_busy(cnt_a, cnt_b);
        check("clr_len32", 32'(cnt_a), 32'd32);
        check("clr_len20", 32'(cnt_b), 32'd20);

        // Back-to-back reads of the whole array
        for (int i = 0; i < D32; i++) begin
            re_a = 1; addr_a = AW'(i);
            step();
            check("init_vld", 32'(vld_a), 32'd1);
            check("init_data", 32'(dout_a), 32'(mdl[i]));
        end
        re_a = 0;
        step();
        check("init_vld_end", 32'(vld_a), 32'd0);

        // DEPTH=20 instance: INIT value, out-of-range write/read
        re_b = 1; addr_b = 5'd19;
        step();
        check("d20_rd19_vld", 32'(vld_b), 32'd1);
        check("d20_rd19", 32'(dout_b), 32'(mdl20[19]));
        re_b = 0; we_b = 1; addr_b = 5'd25; din_b = 10'h3C3;
        step();
        check("d20_wr25_vld", 32'(vld_b), 32'd0);
        we_b = 0; re_b = 1;
        step();
        check("d20_rd25_vld", 32'(vld_b), 32'd1);
        check("d20_rd25", 32'(dout_b), 32'd0);
        addr_b = 5'd6;
        step();
        check("d20_rd6", 32'(dout_b), 32'(mdl20[6]));
        re_b = 0;

        // Write then read, single-cycle strobe, data holds
        write_a(3, 'h2A5);
        read_a("wr_rd3", 3);
        step();
        check("rd3_pulse", 32'(vld_a), 32'd0);
        check("rd3_hold", 32'(dout_a), 32'h2A5);

        // Read-first on simultaneous write/read
        write_a(7, 'h011);
        we_a = 1; re_a = 1; addr_a = 5'd7; din_a = 10'h3FF;
        step();
        we_a = 0; re_a = 0;
        check("rf_vld", 32'(vld_a), 32'd1);
        check("rf_old", 32'(dout_a), 32'h011);
        mdl[7] = 'h3FF;
        read_a("rf_new", 7);

        // Randomized traffic against the array model
        exp_data = int'(dout_a);
        for (int n = 0; n < 300; n++) begin
            int a, d;
            logic w, r;
            a = int'($urandom_range(D32 - 1));
            d = int'($urandom_range(1023));
            w = 1'($urandom_range(1));
            r = 1'($urandom_range(1));
            we_a = w; re_a = r; addr_a = AW'(a); din_a = DW'(d);
            step();
            if (r) exp_data = mdl[a];
            if (w) mdl[a] = d;
            check("rnd_vld", 32'(vld_a), 32'(r));
            check("rnd_data", 32'(dout_a), 32'(exp_data));
        end
        idle_a();
        step();

        // Clear request collides with write/read: clear wins
        write_a(5, 'h1AB);
        read_a("pre_clr", 5);
        clr_a = 1; we_a = 1; re_a = 1; addr_a = 5'd5; din_a = 10'h0F0;
        step();
        check("clr_vld", 32'(vld_a), 32'd0);
        check("clr_busy", 32'(busy_a), 32'd1);
        cnt_a = 0;
        for (int c = 0; c < 100 && busy_a; c++) begin
            cnt_a++;
            clr_a = 1'($urandom_range(1));
            we_a = 1; re_a = 1;
            addr_a = AW'($urandom_range(D32 - 1));
            din_a = DW'($urandom_range(1023));
            step();
            check("busy_vld", 32'(vld_a), 32'd0);
            check("busy_hold", 32'(dout_a), 32'h1AB);
        end
        idle_a();
        check("clr_len_req", 32'(cnt_a), 32'd32);
        for (int i = 0; i < D32; i++) mdl[i] = 0;
        read_a("post_clr5", 5);
        for (int k = 0; k < 4; k++) read_a("post_clr_rnd", int'($urandom_range(D32 - 1)));

`ifdef MEM_PARITY_EN
        // Parity injection and detection
        inj_a = 1;
        write_a(2, 'h001);
        inj_a = 0;
        re_a = 1; addr_a = 5'd2;
        step();
        check("par_rd2_err", 32'(perr_a), 32'd1);
        check("par_rd2_data", 32'(dout_a), 32'h001);
        addr_a = 5'd4;
        step();
        check("par_rd4_err", 32'(perr_a), 32'd0);
        re_a = 0;
        step();
        check("par_idle", 32'(perr_a), 32'd0);
`endif

        // Reset asserted mid-clear
        write_a(3, 'h2A5);
        read_a("pre_rst", 3);
        clr_a = 1;
        step();
        clr_a = 0;
        for (int c = 0; c < 9; c++) step();
        check("midclr_busy", 32'(busy_a), 32'd1);
        check("midclr_hold", 32'(dout_a), 32'h2A5);
        rst_n = 0;
        #1;
        check("async_busy", 32'(busy_a), 32'd1);
        check("async_dout", 32'(dout_a), 32'd0);
        step(); step();
        rst_n = 1;
        count_busy(cnt_a, cnt_b);
        check("reclr_len32", 32'(cnt_a), 32'd32);
        check("reclr_len20", 32'(cnt_b), 32'd20);
        for (int i = 0; i < D32; i++) mdl[i] = 0;
        read_a("reclr_rd3", 3);
        read_a("reclr_rd31", 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
